// File: rtl/halfword_dot_quant.sv
// -----------------------------------------------------------------------------
// halfword_dot_quant
//   Snapshots 16 signed halfword taps on a start pulse, computes the signed dot
//   product against a 16-entry coefficient bank (one MAC per cycle), then
//   requantizes the sum to 16 bits: arithmetic right shift by shamt with
//   round-half-up, saturating to the signed 16-bit range. The result is offered
//   on a valid/ready port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   taps       flattened taps, tap i at [16i+15:16i], tap 0 newest
//   start      compute request, honoured only in IDLE
//   shamt      right-shift amount 0..31, captured with start
//   coef_we    coefficient write strobe (applied in IDLE and OUT only)
//   coef_addr  coefficient index
//   coef_data  signed coefficient value
//   busy       high in BUSY, ROUND and OUT
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   signed quantized result
//   out_sat    result was saturated (qualified by out_valid)
// -----------------------------------------------------------------------------
module halfword_dot_quant #(
    parameter int N_TAPS = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_TAPS*DATA_W-1:0]   taps,
    input  logic                       start,
    input  logic [4:0]                 shamt,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic [DATA_W-1:0]          coef_data,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sat
);

    localparam int IDX_W = $clog2(N_TAPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    logic [1:0]              state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [4:0]              shamt_reg;
    logic signed [DATA_W-1:0] snap_reg [N_TAPS];
    logic signed [DATA_W-1:0] coef_reg [N_TAPS];

    logic start_accept;
    logic coef_write_ok;

    assign start_accept  = (state_reg == ST_IDLE) && start;
    // The bank is frozen while the MAC walks it, so a computation always sees
    // one consistent set of coefficients.
    assign coef_write_ok = coef_we && ((state_reg == ST_IDLE) || (state_reg == ST_OUT));

    // Snapshot and coefficient registers, one per tap.
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_reg[gi] <= '0;
                end else if (start_accept) begin
                    snap_reg[gi] <= taps[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    coef_reg[gi] <= '0;
                end else if (coef_write_ok && (coef_addr == IDX_W'(gi))) begin
                    coef_reg[gi] <= coef_data;
                end
            end
        end
    endgenerate

    // One multiply-accumulate per cycle.
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = snap_reg[idx_reg] * coef_reg[idx_reg];
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Requantization. One guard bit above the accumulator keeps the rounding
    // bias addition exact regardless of accumulator headroom.
    logic [ACC_W:0]        bias;
    logic [ACC_W:0]        rnd_sum;
    logic signed [ACC_W:0] shifted;
    logic                  in_range;

    always_comb begin
        // 2^(shamt-1), and zero when shamt is zero.
        bias     = ({{ACC_W{1'b0}}, 1'b1} << shamt_reg) >> 1;
        rnd_sum  = {acc_reg[ACC_W-1], acc_reg} + bias;
        shifted  = $signed(rnd_sum) >>> shamt_reg;
        // Fits in DATA_W signed bits iff all bits from the DATA_W-1 position up
        // are copies of the sign.
        in_range = (&shifted[ACC_W:DATA_W-1]) || !(|shifted[ACC_W:DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            acc_reg   <= '0;
            shamt_reg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shamt_reg <= shamt;
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_reg <= acc_reg + prod_ext;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == IDX_W'(N_TAPS-1)) begin
                        state_reg <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (in_range) begin
                        out_data <= shifted[DATA_W-1:0];
                        out_sat  <= 1'b0;
                    end else if (shifted[ACC_W]) begin
                        out_data <= {1'b1, {(DATA_W-1){1'b0}}};
                        out_sat  <= 1'b1;
                    end else begin
                        out_data <= {1'b0, {(DATA_W-1){1'b1}}};
                        out_sat  <= 1'b1;
                    end
                    out_valid <= 1'b1;
                    state_reg <= ST_OUT;
                end
                default: begin // ST_OUT
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_halfword_dot_quant.sv
// -----------------------------------------------------------------------------
// tb_halfword_dot_quant
//   Directed bench for halfword_dot_quant with hand-computed expected results.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_halfword_dot_quant;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] taps;
    logic         start;
    logic [4:0]   shamt;
    logic         coef_we;
    logic [3:0]   coef_addr;
    logic [15:0]  coef_data;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    halfword_dot_quant dut (
        .clk       (clk),
        .rst       (rst),
        .taps      (taps),
        .start     (start),
        .shamt     (shamt),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        step();
        coef_we   = 1'b0;
    endtask

    task automatic set_all_coefs(input logic [15:0] d);
        for (int i = 0; i < 16; i++) write_coef(4'(i), d);
    endtask

    task automatic set_taps_seq();
        for (int i = 0; i < 16; i++) taps[16*i +: 16] = 16'(i + 1);
    endtask

    task automatic set_taps_all(input logic [15:0] d);
        for (int i = 0; i < 16; i++) taps[16*i +: 16] = d;
    endtask

    // Pulse start for one edge (E0).
    task automatic launch(input logic [4:0] s);
        start = 1'b1;
        shamt = s;
        step();
        start = 1'b0;
    endtask

    // Cycles after E0 until out_valid is seen, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Full transaction with out_ready already high.
    task automatic calc(input string tag, input logic [4:0] s,
                        input logic [15:0] exp_data, input logic exp_sat);
        int lat;
        launch(s);
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " data"}, 32'(out_data), 32'(exp_data));
        check({tag, " sat"}, 32'(out_sat), 32'(exp_sat));
        step();
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " busy drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        rst = 1'b1; taps = '0; start = 1'b0; shamt = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;

        // Reset
        step(); step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset data", 32'(out_data), 32'd0);
        check("reset sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        step();
        set_taps_seq();
        calc("cleared coefs", 5'd0, 16'h0000, 1'b0);

        // Basic MAC: sum 1..16 = 136; taps change after E0 must not matter
        set_all_coefs(16'd1);
        set_taps_seq();
        launch(5'd0);
        set_taps_all(16'h7FFF);
        wait_valid(lat);
        check("basic latency", 32'(lat), 32'd17);
        check("basic busy at valid", 32'(busy), 32'd1);
        check("basic data", 32'(out_data), 32'h0088);
        check("basic sat", 32'(out_sat), 32'd0);
        step();
        check("basic busy falls", 32'(busy), 32'd0);
        check("basic valid falls", 32'(out_valid), 32'd0);

        // Coef write during BUSY is dropped (would give 136+4*255=1156)
        set_taps_seq();
        launch(5'd0);
        step(); step();
        write_coef(4'd3, 16'h0100);
        wait_valid(lat);
        check("busy write data", 32'(out_data), 32'h0088);
        step();
        calc("busy write rerun", 5'd0, 16'h0088, 1'b0);

        // Backpressure: hold 5 cycles, starts ignored
        out_ready = 1'b0;
        launch(5'd0);
        wait_valid(lat);
        held = out_data;
        check("bp data", 32'(held), 32'h0088);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            step();
            check("bp hold data", 32'(out_data), 32'(held));
            check("bp hold valid", 32'(out_valid), 32'd1);
        end
        start = 1'b1;            // start on the handshake edge is ignored
        out_ready = 1'b1;
        step();
        check("bp hs valid", 32'(out_valid), 32'd0);
        check("bp hs busy", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        check("bp start ignored", 32'(busy), 32'd0);
        check("bp data kept", 32'(out_data), 32'h0088);

        // Coef write coincident with accepted start is used: coef0=2 -> 137
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd2;
        launch(5'd0);
        coef_we = 1'b0;
        wait_valid(lat);
        check("coincident write data", 32'(out_data), 32'd137);
        step();

        // Saturation and rounding: 16*32767^2 = 17178820624
        set_all_coefs(16'h7FFF);
        set_taps_all(16'h7FFF);
        calc("sat pos", 5'd0, 16'h7FFF, 1'b1);
        calc("shift20", 5'd20, 16'h3FFF, 1'b0);

        // Negative rounding: (-3 + 1) >>> 1 = -1
        set_all_coefs(16'h0000);
        write_coef(4'd0, 16'd1);
        set_taps_all(16'h0000);
        taps[15:0] = 16'hFFFD;
        calc("neg round", 5'd1, 16'hFFFF, 1'b0);
        // (-32768)*(-32768) = 2^30 -> positive saturation
        write_coef(4'd0, 16'h8000);
        taps[15:0] = 16'h8000;
        calc("min*min", 5'd0, 16'h7FFF, 1'b1);
        // (-32768)*32767 -> negative saturation
        write_coef(4'd0, 16'h7FFF);
        calc("sat neg", 5'd0, 16'h8000, 1'b1);

        // Reset mid-operation at E8
        set_all_coefs(16'd1);
        set_taps_seq();
        launch(5'd0);
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst data", 32'(out_data), 32'd0);
        check("midrst sat", 32'(out_sat), 32'd0);
        step();
        calc("after midrst", 5'd0, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
